ixc_gfifo_drain: RTL and testbench
==================================

Name: ixc_gfifo_drain

Overview:
Consumer end of the GFIFO callback-request protocol. Accepts the transactions that GFIFO ports enqueue. Each transaction is a GFtsReq strobe carrying cbid, len and a 512-bit idata word. The block buffers them in a local circular FIFO and drives GFfull back to the ports. It serialises each entry onto a 32-bit valid/ready stream toward the host-side transport as one header word followed by the payload words.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
CBID_W, 20, callback id width
LEN_W, 12, payload length field width, in bits of idata
DATA_W, 512, idata width; must be a multiple of OUT_W
OUT_W, 32, output stream word width; must be at least CBID_W+LEN_W

Ports:
fclk  in  1  fabric clock; all logic is on its rising edge
rst  in  1  reset, synchronous, active-high
GFtsReq  in  1  enqueue strobe; one transaction per high cycle
GFcbid  in  CBID_W  callback id, qualified by GFtsReq
GFlen  in  LEN_W  payload length in bits, qualified by GFtsReq
GFidata  in  DATA_W  payload, qualified by GFtsReq
GFfull  out  1  no free entry; ports must not strobe
ovalid  out  1  output word valid
odata  out  OUT_W  output word
olast  out  1  final word of the current entry
oready  in  1  downstream accept
ovf  out  1  sticky: GFtsReq seen while GFfull was high
lenerr  out  1  sticky: an entry with len > DATA_W was emitted
occ  out  clog2(DEPTH)+1  current entry count

Behaviour:
- Reset: synchronous and active-high; one clock with rst=1 is sufficient.
  - Outputs after reset: GFfull=0, ovalid=0, odata=0, olast=0, ovf=0, lenerr=0, occ=0.
  - Pointers and FIFO contents are cleared; the FSM goes to IDLE.
  - Reset asserted mid-entry aborts the entry with no olast. Downstream discards any partial entry after reset.
- Enqueue:
  - wr = GFtsReq & ~GFfull. The entry is written at wptr on that edge and wptr increments modulo DEPTH.
  - GFtsReq & GFfull: the request is dropped, ovf is set and stays set until reset, and the FIFO is unchanged.
- GFfull = (occ == DEPTH), decoded from registered occ with no combinational path from GFtsReq.
- Simultaneous enqueue and dequeue: occ is unchanged.
  - When full, the pop frees a slot, but an enqueue in that same cycle is still refused because GFfull was high.
- Entry word count: nw = ceil(min(len, DATA_W)/OUT_W).
  - len=0 gives nw=0: the entry is a header word only.
  - len > DATA_W is clamped to nw = DATA_W/OUT_W (16 at defaults) and sets lenerr when the header is emitted.
- FSM with states IDLE, HDR, DATA:
  - IDLE: if occ != 0, go to HDR next cycle. One bubble cycle is allowed.
  - HDR: ovalid=1 and odata = {len, cbid}, with cbid in the LSBs, zero-extended to OUT_W.
    - olast = (nw == 0).
    - On ovalid & oready with nw == 0: pop the entry and go to IDLE, or to HDR if occ > 1 after the pop.
    - Otherwise on ovalid & oready: widx=0 and go to DATA.
  - DATA: odata = idata[widx*OUT_W +: OUT_W], sending the LSB word first; olast = (widx == nw-1).
    - On accept: widx increments.
    - On accepting the last word: pop the entry, then go to HDR if entries remain, else IDLE.
- Output stability: ovalid, odata and olast are registered. They hold stable while ovalid & ~oready, so backpressure on any cycle is legal.
- Throughput: back-to-back entries with no bubble while occ > 1 and oready=1. Latency from GFtsReq into an empty FIFO to ovalid is 2 cycles.
- The pointer wrap at DEPTH is seamless. occ saturates structurally at DEPTH because wr is gated by GFfull.

Decomposition:
- Package ixc_gfifo_pkg holds:
  - the FSM state enum {IDLE, HDR, DATA};
  - a struct gf_entry_t {cbid, len, idata};
  - constants GF_CBID_W=20, GF_LEN_W=12, GF_DATA_W=512;
  - a function gf_nwords(len) returning the clamped ceil.
- One sub-module, ixc_gfifo_drain_mem: a DEPTH-entry gf_entry_t storage with wptr, rptr, occ, push, pop and registered full.
- The serialiser FSM stays in the top module.

Test Plan:
- Single entry: cbid=0x12345, len=64, idata[63:0]=0xCAFEBABE_DEADBEEF with oready=1.
  - Output: 3 words: 0x04012345, then 0xDEADBEEF, then 0xCAFEBABE with olast on the third; occ returns to 0.
- len=0 entry with cbid=7: one word 0x00000007 with olast=1.
- len=4095 entry: header word, then 16 data words; lenerr=1 and olast on word 16.
- Fill with oready=0: strobe 9 times.
  - After 8 accepted, GFfull=1 and occ=8; the 9th strobe sets ovf and is dropped.
  - With oready=1, the first 8 entries drain in order.
- Full with simultaneous pop: occ=8, oready=1 and GFtsReq on the pop cycle.
  - The request is refused and ovf is set; next cycle GFfull=0 and a new strobe is accepted.
- Random oready toggling over 1000 random entries (len 0..600): the scoreboard matches every word in order, odata is stable under stall, and the pointers wrap correctly.
- rst pulse during the DATA phase of entry 2 of 3: next cycle ovalid=0 and occ=0; after reset, a new entry emits cleanly.

Source files
------------

// File: rtl/ixc_gfifo_pkg.sv
`default_nettype none
// ============================================================================
// ixc_gfifo_pkg : shared types and helpers for the GFIFO drain block
// Rev 1.0
// ============================================================================
package ixc_gfifo_pkg;

  localparam int GF_CBID_W = 20;
  localparam int GF_LEN_W  = 12;
  localparam int GF_DATA_W = 512;
  localparam int GF_OUT_W  = 32;
  localparam int GF_MAXW   = GF_DATA_W / GF_OUT_W;
  localparam int GF_NW_W   = $clog2(GF_MAXW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } gf_state_t;

  typedef struct packed {
    logic [GF_CBID_W-1:0] cbid;
    logic [GF_LEN_W-1:0]  len;
    logic [GF_DATA_W-1:0] idata;
  } gf_entry_t;

  // Payload word count; lengths beyond the data word clamp to a full word set.
  function automatic logic [GF_NW_W-1:0] gf_nwords(input logic [GF_LEN_W-1:0] len);
    logic [GF_LEN_W:0] w;
    if (len > GF_LEN_W'(GF_DATA_W)) begin
      w = (GF_LEN_W+1)'(GF_MAXW);
    end else begin
      w = ({1'b0, len} + (GF_LEN_W+1)'(GF_OUT_W - 1)) / (GF_LEN_W+1)'(GF_OUT_W);
    end
    return w[GF_NW_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ixc_gfifo_drain_mem.sv
`default_nettype none
// ============================================================================
// ixc_gfifo_drain_mem : circular entry store with occupancy and registered full
// Rev 1.0
// ============================================================================
module ixc_gfifo_drain_mem
  import ixc_gfifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  gf_entry_t                  i_wdata,
  input  logic                       i_pop,
  output gf_entry_t                  o_head,
  output logic [GF_CBID_W-1:0]       o_nxt_cbid,
  output logic [GF_LEN_W-1:0]        o_nxt_len,
  output logic [$clog2(DEPTH):0]     o_occ,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  gf_entry_t      mem_q [DEPTH];
  gf_entry_t      mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW-1:0]  rptr_nxt;
  logic [AW:0]    occ_q, occ_d;
  logic           full_q, full_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (i_push) begin
      mem_d[wptr_q] = i_wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (i_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({i_push, i_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    full_d = (occ_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      full_q <= full_d;
    end
  end

  // The entry behind the head lets the serialiser chain headers without a bubble.
  assign rptr_nxt   = rptr_q + 1'b1;
  assign o_head     = mem_q[rptr_q];
  assign o_nxt_cbid = mem_q[rptr_nxt].cbid;
  assign o_nxt_len  = mem_q[rptr_nxt].len;
  assign o_occ      = occ_q;
  assign o_full     = full_q;

endmodule
`default_nettype wire

// File: rtl/ixc_gfifo_drain.sv
`default_nettype none
// ============================================================================
// ixc_gfifo_drain : buffers GFIFO callback requests and serialises each entry
//                   as a header word plus payload words on a valid/ready stream
// Rev 1.0
// ============================================================================
module ixc_gfifo_drain
  import ixc_gfifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CBID_W = GF_CBID_W,
  parameter int LEN_W  = GF_LEN_W,
  parameter int DATA_W = GF_DATA_W,
  parameter int OUT_W  = GF_OUT_W
) (
  input  logic                      fclk,
  input  logic                      rst,
  input  logic                      GFtsReq,
  input  logic [CBID_W-1:0]         GFcbid,
  input  logic [LEN_W-1:0]          GFlen,
  input  logic [DATA_W-1:0]         GFidata,
  output logic                      GFfull,
  output logic                      ovalid,
  output logic [OUT_W-1:0]          odata,
  output logic                      olast,
  input  logic                      oready,
  output logic                      ovf,
  output logic                      lenerr,
  output logic [$clog2(DEPTH):0]    occ
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  gf_entry_t            wr_entry;
  gf_entry_t            head;
  logic [CBID_W-1:0]    nxt_cbid;
  logic [LEN_W-1:0]     nxt_len;
  logic [OCC_W-1:0]     occ_w;
  logic                 full_w;
  logic                 wr;
  logic                 pop;
  logic                 accept;
  logic [GF_NW_W-1:0]   head_nw;
  logic [GF_NW_W-1:0]   nxt_nw;
  logic [GF_NW_W-1:0]   widx_inc;

  gf_state_t            state_q, state_d;
  logic                 ovalid_q, ovalid_d;
  logic [OUT_W-1:0]     odata_q, odata_d;
  logic                 olast_q, olast_d;
  logic [GF_NW_W-1:0]   widx_q, widx_d;
  logic                 ovf_q, ovf_d;
  logic                 lenerr_q, lenerr_d;

  function automatic logic [OUT_W-1:0] hdr_word(input logic [CBID_W-1:0] cb,
                                                input logic [LEN_W-1:0]  ln);
    logic [OUT_W-1:0] w;
    w = '0;
    w[CBID_W+LEN_W-1:0] = {ln, cb};
    return w;
  endfunction

  assign wr             = GFtsReq & ~full_w;
  assign wr_entry.cbid  = GFcbid;
  assign wr_entry.len   = GFlen;
  assign wr_entry.idata = GFidata;

  ixc_gfifo_drain_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (fclk),
    .rst        (rst),
    .i_push     (wr),
    .i_wdata    (wr_entry),
    .i_pop      (pop),
    .o_head     (head),
    .o_nxt_cbid (nxt_cbid),
    .o_nxt_len  (nxt_len),
    .o_occ      (occ_w),
    .o_full     (full_w)
  );

  assign accept  = ovalid_q & oready;
  assign head_nw = gf_nwords(head.len);
  assign nxt_nw  = gf_nwords(nxt_len);

  always_comb begin
    state_d  = state_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    widx_d   = widx_q;
    lenerr_d = lenerr_q;
    ovf_d    = ovf_q | (GFtsReq & full_w);
    pop      = 1'b0;
    widx_inc = widx_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (occ_w != '0) begin
          state_d  = HDR;
          ovalid_d = 1'b1;
          odata_d  = hdr_word(head.cbid, head.len);
          olast_d  = (head_nw == '0);
        end
      end
      HDR: begin
        if (accept) begin
          if (head.len > LEN_W'(DATA_W)) begin
            lenerr_d = 1'b1;
          end
          if (head_nw == '0) begin
            pop = 1'b1;
          end else begin
            state_d = DATA;
            widx_d  = '0;
            odata_d = head.idata[0 +: OUT_W];
            olast_d = (head_nw == GF_NW_W'(1));
          end
        end
      end
      DATA: begin
        if (accept) begin
          if (olast_q) begin
            pop = 1'b1;
          end else begin
            widx_d  = widx_inc;
            odata_d = head.idata[widx_inc*OUT_W +: OUT_W];
            olast_d = (widx_inc == head_nw - 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // After a pop, present the following header at once if one is stored.
    if (pop) begin
      if (occ_w > OCC_W'(1)) begin
        state_d  = HDR;
        ovalid_d = 1'b1;
        odata_d  = hdr_word(nxt_cbid, nxt_len);
        olast_d  = (nxt_nw == '0);
      end else begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
        odata_d  = '0;
        olast_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q  <= IDLE;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
      widx_q   <= '0;
      ovf_q    <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      olast_q  <= olast_d;
      widx_q   <= widx_d;
      ovf_q    <= ovf_d;
      lenerr_q <= lenerr_d;
    end
  end

  assign GFfull = full_w;
  assign ovalid = ovalid_q;
  assign odata  = odata_q;
  assign olast  = olast_q;
  assign ovf    = ovf_q;
  assign lenerr = lenerr_q;
  assign occ    = occ_w;

endmodule
`default_nettype wire

// File: tb/tb_ixc_gfifo_drain.sv
`default_nettype none
// ============================================================================
// tb_ixc_gfifo_drain : randomized scoreboard bench for the GFIFO drain block
// Rev 1.0
// ============================================================================
module tb_ixc_gfifo_drain;

  localparam int DEPTH  = 8;
  localparam int CBID_W = 20;
  localparam int LEN_W  = 12;
  localparam int DATA_W = 512;
  localparam int OUT_W  = 32;
  localparam int OCC_W  = 4;

  logic              fclk = 1'b0;
  logic              rst = 1'b1;
  logic              GFtsReq = 1'b0;
  logic [CBID_W-1:0] GFcbid = '0;
  logic [LEN_W-1:0]  GFlen = '0;
  logic [DATA_W-1:0] GFidata = '0;
  logic              GFfull;
  logic              ovalid;
  logic [OUT_W-1:0]  odata;
  logic              olast;
  logic              oready = 1'b0;
  logic              ovf;
  logic              lenerr;
  logic [OCC_W-1:0]  occ;

  ixc_gfifo_drain #(
    .DEPTH(DEPTH), .CBID_W(CBID_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .OUT_W(OUT_W)
  ) dut (
    .fclk(fclk), .rst(rst), .GFtsReq(GFtsReq), .GFcbid(GFcbid), .GFlen(GFlen),
    .GFidata(GFidata), .GFfull(GFfull), .ovalid(ovalid), .odata(odata),
    .olast(olast), .oready(oready), .ovf(ovf), .lenerr(lenerr), .occ(occ)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        lerr;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cnt = 0;
  logic        ovf_e = 1'b0;
  logic        lenerr_e = 1'b0;
  logic        chk_rst = 1'b0;
  logic        stall_v = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;
  exp_t        mon_e;
  logic        mon_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: header {len,cbid}, then ceil(min(len,512)/32) payload words, LSB first.
  task automatic model_push(input logic [CBID_W-1:0] cb, input logic [LEN_W-1:0] ln,
                            input logic [DATA_W-1:0] d);
    int   nw;
    exp_t e;
    if (ln == 0)        nw = 0;
    else if (ln > 512)  nw = 16;
    else                nw = (int'(ln) + 31) / 32;
    e.data = {ln, cb};
    e.last = (nw == 0);
    e.lerr = (ln > 512);
    sbq.push_back(e);
    for (int i = 0; i < nw; i++) begin
      e.data = d[i*32 +: 32];
      e.last = (i == nw - 1);
      e.lerr = 1'b0;
      sbq.push_back(e);
    end
  endtask

  // Monitor: samples mid-cycle, checks status outputs, pops the scoreboard on handshakes.
  always @(negedge fclk) begin
    if (chk_rst) begin
      check("rst_ovalid", ovalid, 0);
      check("rst_odata", odata, 0);
      check("rst_olast", olast, 0);
      chk_rst = 1'b0;
    end
    check("occ", occ, cnt);
    check("gffull", GFfull, cnt == DEPTH);
    check("ovf", ovf, ovf_e);
    check("lenerr", lenerr, lenerr_e);
    if (stall_v) begin
      check("stall_valid", ovalid, 1);
      check("stall_data", odata, stall_d);
      check("stall_last", olast, stall_l);
    end
    stall_v = 1'b0;
    if (rst) begin
      sbq.delete();
      cnt      = 0;
      ovf_e    = 1'b0;
      lenerr_e = 1'b0;
      chk_rst  = 1'b1;
    end else begin
      mon_pop = 1'b0;
      if (ovalid) begin
        if (!oready) begin
          stall_v = 1'b1;
          stall_d = odata;
          stall_l = olast;
        end else if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word actual=%h required=none at %0t", odata, $time);
        end else begin
          mon_e = sbq.pop_front();
          check("word_data", odata, mon_e.data);
          check("word_last", olast, mon_e.last);
          if (mon_e.lerr) lenerr_e = 1'b1;
          if (mon_e.last) mon_pop = 1'b1;
        end
      end
      if (GFtsReq) begin
        if (cnt == DEPTH) begin
          ovf_e = 1'b1;
        end else begin
          model_push(GFcbid, GFlen, GFidata);
          cnt++;
        end
      end
      if (mon_pop) cnt--;
    end
  end

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic rand_data(output logic [DATA_W-1:0] d);
    for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
  endtask

  task automatic drive(input logic [CBID_W-1:0] cb, input logic [LEN_W-1:0] ln,
                       input logic [DATA_W-1:0] d);
    GFtsReq = 1'b1;
    GFcbid  = cb;
    GFlen   = ln;
    GFidata = d;
  endtask

  task automatic drain(input string name);
    bit done;
    done    = 1'b0;
    GFtsReq = 1'b0;
    oready  = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (sbq.size() == 0 && cnt == 0 && !ovalid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d words pending required=0", name, sbq.size());
    end
  endtask

  logic [DATA_W-1:0] d;
  int                n;
  int                cyc;
  bit                found;

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Single entry with latency probe
    d = '0;
    d[63:0] = 64'hCAFEBABE_DEADBEEF;
    oready = 1'b1;
    drive(20'h12345, 12'd64, d);
    tick();
    GFtsReq = 1'b0;
    @(negedge fclk);
    check("latency_cycle1", ovalid, 0);
    @(posedge fclk);
    @(negedge fclk);
    check("latency_cycle2", ovalid, 1);
    drain("single");

    // Header-only entry
    drive(20'h7, 12'd0, '0);
    tick();
    drain("len0");

    // Oversize length clamps to 16 words and raises lenerr
    rand_data(d);
    drive(20'hABCDE, 12'd4095, d);
    tick();
    drain("len4095");

    // Fill with backpressure; the ninth strobe overflows
    oready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_data(d);
      drive(20'(i + 100), 12'(32 * (i % 3) + 8), d);
      tick();
    end
    GFtsReq = 1'b0;
    repeat (4) tick();
    @(negedge fclk);
    check("fill_full", GFfull, 1);
    check("fill_occ", occ, 8);
    check("fill_ovf", ovf, 1);
    drain("fill");

    // Full with a strobe held across the pop cycles
    oready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_data(d);
      drive(20'(i + 200), 12'(40), d);
      tick();
    end
    oready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rand_data(d);
      drive(20'(i + 300), 12'($urandom_range(0, 100)), d);
      tick();
    end
    drain("fullpop");

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random traffic with random backpressure
    n   = 0;
    cyc = 0;
    while (n < 1000 && cyc < 60000) begin
      GFtsReq = 1'b0;
      if (!GFfull && ($urandom % 3 == 0)) begin
        rand_data(d);
        drive(20'($urandom), 12'($urandom_range(0, 600)), d);
        n++;
      end
      oready = ($urandom % 4 != 0);
      tick();
      cyc++;
    end
    if (n < 1000) begin
      checks++;
      errors++;
      $display("FAIL random_budget actual=%0d entries required=1000", n);
    end
    drain("random");

    // Reset during the payload of the second of three entries
    oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data(d);
      drive(20'(i + 500), 12'd128, d);
      tick();
    end
    GFtsReq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge fclk);
      if (ovalid && oready && olast) found = 1'b1;
    end
    check("midrst_first_entry", found, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge fclk);
    check("midrst_ovalid", ovalid, 0);
    check("midrst_occ", occ, 0);
    tick();
    rand_data(d);
    drive(20'h55555, 12'd96, d);
    tick();
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
